// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the two register-file writers (A = ALU writeback, B = load unit)
// and rf_write_arbiter, plus the registered register-file write port and busy flag.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32
);
    // Handshake: a write transfers on a rising edge where valid && ready. The requester
    // holds valid, reg and data stable until that edge, and valid never waits on ready.
    logic              a_valid;
    logic [4:0]        a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [4:0]        b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              rf_reg_write;
    logic [4:0]        rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              busy;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, rf_reg_write, rf_write_reg, rf_write_data, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, rf_reg_write, rf_write_reg, rf_write_data, busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, dropping x0 writes.
// Define RF_WRITE_ARB_CLEAR_EN to zero-fill all registers after every reset.
module rf_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    logic              run;
    logic              last_b;
    logic              grant_a;
    logic              grant_b;
    logic [4:0]        win_reg;
    logic [DATA_W-1:0] win_data;

`ifdef RF_WRITE_ARB_CLEAR_EN
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] clr_idx;

    assign run = (state == RUN);
`else
    assign run = 1'b1;
`endif

    // On a tie the side that did not win the last accepted handshake goes next.
    assign grant_a = reset & run & bus.a_valid & (~bus.b_valid | last_b);
    assign grant_b = reset & run & bus.b_valid & (~bus.a_valid | ~last_b);

    assign win_reg  = grant_b ? bus.b_reg  : bus.a_reg;
    assign win_data = grant_b ? bus.b_data : bus.a_data;

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
    assign bus.busy    = ~run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rf_reg_write  <= 1'b0;
            bus.rf_write_reg  <= 5'd0;
            bus.rf_write_data <= '0;
            last_b            <= 1'b1;
`ifdef RF_WRITE_ARB_CLEAR_EN
            state             <= CLEAR;
            clr_idx           <= 5'd0;
`endif
        end else begin
`ifdef RF_WRITE_ARB_CLEAR_EN
            if (state == CLEAR) begin
                // Clear writes include index 0 so the whole array is known-zero.
                bus.rf_reg_write  <= 1'b1;
                bus.rf_write_reg  <= clr_idx;
                bus.rf_write_data <= '0;
                clr_idx           <= clr_idx + 5'd1;
                if (clr_idx == LAST_IDX) begin
                    state <= RUN;
                end
            end else
`endif
            if (grant_a | grant_b) begin
                bus.rf_reg_write  <= (win_reg != 5'd0);
                bus.rf_write_reg  <= win_reg;
                bus.rf_write_data <= win_data;
                last_b            <= grant_b;
            end else begin
                bus.rf_reg_write <= 1'b0;
            end
        end
    end
endmodule
